btn_encoder: RTL and testbench
==============================

BTN_ENCODER -- requirements
Module: btn_encoder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flops per raw button.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles to accept a level change (range 1..65535).
REQ-003 Parameter HOLD_DELAY, default 8: cycles from first pulse to first auto-repeat pulse (range 2..65535).
REQ-004 Parameter REPEAT_PERIOD, default 4: cycles between auto-repeat pulses (range 2..65535).
REQ-005 Reset rst, asynchronous, active-high; clock btnClk.
REQ-006 btnClk  in  1  step clock, shared with the position consumer.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 btnU_raw, btnD_raw, btnR_raw, btnL_raw  in  1 each  raw, asynchronous, bouncing pushbutton levels, active-high.
REQ-009 enable  in  1  encoder enable; low forces idle.
REQ-010 btns  out  4  one-cycle step code: 8=up, 4=down, 2=right, 1=left, 0=no step.
REQ-011 btn_held  out  1  high while a single direction is held past its first pulse.

Function
REQ-012 Each raw input SHALL pass SYNC_STAGES flops, then a debouncer; debounced bit changes only after the synced value differs from it for DEBOUNCE_CYCLES consecutive cycles, and the counter clears on any agreeing sample.
REQ-013 Debounced vector D = {U,D,R,L}; "valid" means D is exactly one-hot; zero or multi-hot is "invalid".
REQ-014 FSM states: IDLE, HOLD, REPEAT; all outputs registered.
REQ-015 IDLE: valid D -> btns = D for exactly one cycle on the next edge, state -> HOLD, interval counter cleared; btn_held = 0.
REQ-016 HOLD: counter increments each cycle with D unchanged; a pulse of D occurs exactly HOLD_DELAY cycles after the initial pulse, then state -> REPEAT, counter cleared, btn_held = 1 from that cycle.
REQ-017 REPEAT: a pulse of D occurs every REPEAT_PERIOD cycles; btn_held stays 1.
REQ-018 In HOLD or REPEAT, D changing to a different valid code -> pulse of the new code on the next edge, state -> HOLD, counter cleared, btn_held = 0.
REQ-019 In any state, invalid D -> state IDLE and btns = 0 on the next edge, btn_held = 0; no pulse for multi-press.
REQ-020 enable low -> state IDLE, btns = 0, btn_held = 0, counters cleared on the next edge; synchronizers and debouncers keep running.
REQ-021 enable rising while D is valid -> treated as a fresh press (REQ-015).
REQ-022 btns SHALL never be nonzero in two consecutive cycles unless REPEAT_PERIOD or HOLD_DELAY allows it (minimum 2, so never back-to-back).
REQ-023 btns SHALL only ever be 0, 1, 2, 4 or 8.
REQ-024 Interval counters are 16 bits, saturate rather than wrap, and are compared to parameter-1.
REQ-025 Latency: raw edge to first btns pulse = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles (7 at defaults).

Reset
REQ-026 rst SHALL asynchronously clear all synchronizer flops, debounced bits, debounce counters and interval counters, set state IDLE, btns = 0, btn_held = 0.
REQ-027 rst mid-hold: no pulse in the release cycle; a still-held button after release is re-debounced from 0 and produces a fresh first pulse per REQ-025.

Structure
REQ-028 Shared package holds BTN_UP=4'd8, BTN_DOWN=4'd4, BTN_RIGHT=4'd2, BTN_LEFT=4'd1, BTN_NONE=4'd0, and the FSM state encoding; the consumer decodes the same constants.
REQ-029 One sub-module, btn_debounce (synchronizer + stable counter, one bit), instantiated four times.

Verification
REQ-030 Reset, hold btnU_raw high 20 cycles from clean -> btns = 8 at cycle 7, next pulse at cycle 15, then 19; btn_held = 1 from cycle 15.
REQ-031 btnR_raw toggling every 2 cycles for 30 cycles, then stable high -> no pulse while toggling; single btns = 2 seven cycles after it becomes stable.
REQ-032 btnU and btnL pressed together 30 cycles -> btns stays 0 throughout; release btnU -> btns = 1 seven cycles later.
REQ-033 Hold down in REPEAT, switch to left (released/pressed on same edge) -> btns = 1 once debounced, btn_held drops to 0, next left pulse 8 cycles later.
REQ-034 Hold right, drop enable for 5 cycles mid-REPEAT, raise it -> btns = 0 while low; btns = 2 on the cycle after enable returns, then HOLD timing restarts.
REQ-035 Assert rst for 1 cycle during HOLD with btnD held -> btns = 0 and btn_held = 0 immediately; first btns = 4 seven cycles after rst release.

Source files
------------

// File: rtl/btn_encoder_pkg.sv
// Shared step codes, FSM encoding and small helpers for the pushbutton encoder.
// The position consumer decodes the same BTN_* constants.
package btn_encoder_pkg;

    localparam logic [3:0] BTN_UP    = 4'd8;
    localparam logic [3:0] BTN_DOWN  = 4'd4;
    localparam logic [3:0] BTN_RIGHT = 4'd2;
    localparam logic [3:0] BTN_LEFT  = 4'd1;
    localparam logic [3:0] BTN_NONE  = 4'd0;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_e;

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Interval counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == CNT_MAX) ? c : (c + 16'd1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One-bit synchronizer chain followed by a stable-level debouncer.
module btn_debounce
    import btn_encoder_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic btnClk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [15:0]            cnt_r;
    logic                   level_r;
    logic                   synced_s;

    assign synced_s = sync_r[SYNC_STAGES-1];
    assign level    = level_r;

    // Metastability chain for the asynchronous raw level.
    always_ff @(posedge btnClk or posedge rst) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES disagreeing samples in a row.
    always_ff @(posedge btnClk or posedge rst) begin
        if (rst) begin
            cnt_r   <= 16'd0;
            level_r <= 1'b0;
        end else if (synced_s == level_r) begin
            cnt_r <= 16'd0;
        end else if (cnt_r == DB_LAST) begin
            cnt_r   <= 16'd0;
            level_r <= synced_s;
        end else begin
            cnt_r <= sat_inc(cnt_r);
        end
    end

endmodule

// File: rtl/btn_encoder.sv
// Four-button step encoder: debounced one-hot presses become single-cycle step
// codes, with a first auto-repeat after HOLD_DELAY and then every REPEAT_PERIOD.
module btn_encoder
    import btn_encoder_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_DELAY      = 8,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic       btnClk,
    input  logic       rst,
    input  logic       btnU_raw,
    input  logic       btnD_raw,
    input  logic       btnR_raw,
    input  logic       btnL_raw,
    input  logic       enable,
    output logic [3:0] btns,
    output logic       btn_held
);

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_DELAY - 1);
    localparam logic [15:0] REP_LAST  = 16'(REPEAT_PERIOD - 1);

    logic [3:0]  deb_s;
    logic        valid_s;
    btn_state_e  state_r;
    btn_state_e  state_next_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_next_s;
    logic [3:0]  code_r;
    logic [3:0]  code_next_s;
    logic [3:0]  btns_next_s;
    logic        held_next_s;

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .btnClk(btnClk), .rst(rst), .raw(btnU_raw), .level(deb_s[3])
    );
    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .btnClk(btnClk), .rst(rst), .raw(btnD_raw), .level(deb_s[2])
    );
    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .btnClk(btnClk), .rst(rst), .raw(btnR_raw), .level(deb_s[1])
    );
    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
        .btnClk(btnClk), .rst(rst), .raw(btnL_raw), .level(deb_s[0])
    );

    assign valid_s = is_one_hot(deb_s);

    // State, interval counter, latched code and registered outputs.
    always_ff @(posedge btnClk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 16'd0;
            code_r   <= BTN_NONE;
            btns     <= BTN_NONE;
            btn_held <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            code_r   <= code_next_s;
            btns     <= btns_next_s;
            btn_held <= held_next_s;
        end
    end

    // Next-state selection; disable or a zero/multi-hot vector always returns to idle.
    always_comb begin
        state_next_s = state_r;
        if (!enable || !valid_s) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_next_s = ST_HOLD;
                ST_HOLD: begin
                    if (deb_s != code_r) begin
                        state_next_s = ST_HOLD;
                    end else if (cnt_r == HOLD_LAST) begin
                        state_next_s = ST_REPEAT;
                    end else begin
                        state_next_s = ST_HOLD;
                    end
                end
                ST_REPEAT: begin
                    if (deb_s != code_r) begin
                        state_next_s = ST_HOLD;
                    end else begin
                        state_next_s = ST_REPEAT;
                    end
                end
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // Next values of the pulse, held flag, interval counter and latched code.
    always_comb begin
        btns_next_s = BTN_NONE;
        held_next_s = 1'b0;
        cnt_next_s  = 16'd0;
        code_next_s = code_r;
        if (!enable || !valid_s) begin
            code_next_s = BTN_NONE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    btns_next_s = deb_s;
                    code_next_s = deb_s;
                end
                ST_HOLD: begin
                    if (deb_s != code_r) begin
                        btns_next_s = deb_s;
                        code_next_s = deb_s;
                    end else if (cnt_r == HOLD_LAST) begin
                        btns_next_s = deb_s;
                        held_next_s = 1'b1;
                    end else begin
                        cnt_next_s = sat_inc(cnt_r);
                    end
                end
                ST_REPEAT: begin
                    if (deb_s != code_r) begin
                        btns_next_s = deb_s;
                        code_next_s = deb_s;
                    end else if (cnt_r == REP_LAST) begin
                        btns_next_s = deb_s;
                        held_next_s = 1'b1;
                    end else begin
                        held_next_s = 1'b1;
                        cnt_next_s  = sat_inc(cnt_r);
                    end
                end
                default: begin
                    code_next_s = BTN_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_encoder.sv
// Directed-vector bench for btn_encoder at default parameters; expected
// per-cycle outputs are written out by hand for each scenario.
module tb_btn_encoder;

    logic       btnClk = 1'b0;
    logic       rst;
    logic       btnU_raw, btnD_raw, btnR_raw, btnL_raw;
    logic       enable;
    logic [3:0] btns;
    logic       btn_held;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [3:0] exp_btns [0:63];
    logic       exp_held [0:63];

    btn_encoder dut (
        .btnClk  (btnClk),
        .rst     (rst),
        .btnU_raw(btnU_raw),
        .btnD_raw(btnD_raw),
        .btnR_raw(btnR_raw),
        .btnL_raw(btnL_raw),
        .enable  (enable),
        .btns    (btns),
        .btn_held(btn_held)
    );

    always #5 btnClk = ~btnClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 64; i++) begin
            exp_btns[i] = 4'd0;
            exp_held[i] = 1'b0;
        end
    endtask

    task automatic held_range(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            exp_held[i] = 1'b1;
        end
    endtask

    // Advance n cycles, comparing outputs after each edge with the expected tables.
    task automatic run(input string tag, input int n);
        for (int k = 1; k <= n; k++) begin
            @(posedge btnClk);
            #1;
            check($sformatf("%s_btns_c%0d", tag, k), 32'(btns), 32'(exp_btns[k]));
            check($sformatf("%s_held_c%0d", tag, k), 32'(btn_held), 32'(exp_held[k]));
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge btnClk);
        #1;
    endtask

    task automatic release_all();
        btnU_raw = 1'b0;
        btnD_raw = 1'b0;
        btnR_raw = 1'b0;
        btnL_raw = 1'b0;
        idle_cycles(12);
        check("released_btns", 32'(btns), 32'd0);
        check("released_held", 32'(btn_held), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b1;
        btnU_raw = 1'b0;
        btnD_raw = 1'b0;
        btnR_raw = 1'b0;
        btnL_raw = 1'b0;
        idle_cycles(2);
        check("reset_btns", 32'(btns), 32'd0);
        check("reset_held", 32'(btn_held), 32'd0);
        rst = 1'b0;

        // Hold up from clean: first pulse at 7, repeats at 15 and 19.
        btnU_raw = 1'b1;
        clear_exp();
        exp_btns[7]  = 4'd8;
        exp_btns[15] = 4'd8;
        exp_btns[19] = 4'd8;
        held_range(15, 20);
        run("hold_up", 20);
        release_all();

        // Bouncing right never settles long enough to be accepted.
        for (int i = 0; i < 30; i++) begin
            btnR_raw = ((i >> 1) & 1) == 1;
            @(posedge btnClk);
            #1;
            check($sformatf("bounce_btns_c%0d", i), 32'(btns), 32'd0);
        end
        btnR_raw = 1'b1;
        clear_exp();
        exp_btns[7] = 4'd2;
        run("settled_right", 8);
        release_all();

        // Up+left together is invalid; dropping up leaves a clean left press.
        btnU_raw = 1'b1;
        btnL_raw = 1'b1;
        clear_exp();
        run("multi_press", 30);
        btnU_raw = 1'b0;
        clear_exp();
        exp_btns[7] = 4'd1;
        run("multi_release", 8);
        release_all();

        // Down into repeat, then switch straight to left.
        btnD_raw = 1'b1;
        clear_exp();
        exp_btns[7]  = 4'd4;
        exp_btns[15] = 4'd4;
        exp_btns[19] = 4'd4;
        held_range(15, 20);
        run("hold_down", 20);
        btnD_raw = 1'b0;
        btnL_raw = 1'b1;
        clear_exp();
        exp_btns[3]  = 4'd4;
        exp_btns[7]  = 4'd1;
        exp_btns[15] = 4'd1;
        held_range(1, 6);
        held_range(15, 16);
        run("switch_left", 16);
        release_all();

        // Enable dropped mid-repeat, then restored as a fresh press.
        btnR_raw = 1'b1;
        clear_exp();
        exp_btns[7]  = 4'd2;
        exp_btns[15] = 4'd2;
        exp_btns[19] = 4'd2;
        held_range(15, 20);
        run("hold_right", 20);
        enable = 1'b0;
        clear_exp();
        run("enable_low", 5);
        enable = 1'b1;
        clear_exp();
        exp_btns[1] = 4'd2;
        exp_btns[9] = 4'd2;
        held_range(9, 10);
        run("enable_back", 10);
        release_all();

        // Async reset while holding down, then a full re-debounce.
        btnD_raw = 1'b1;
        clear_exp();
        exp_btns[7] = 4'd4;
        run("rst_pre", 7);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_btns", 32'(btns), 32'd0);
        check("rst_async_held", 32'(btn_held), 32'd0);
        @(posedge btnClk);
        #1;
        rst = 1'b0;
        clear_exp();
        exp_btns[7] = 4'd4;
        run("rst_post", 8);
        release_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
